axis_pkt_arbiter: RTL and testbench
===================================

Name: axis_pkt_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one AXI-Stream FIFO slave port (64-bit tdata, 8-bit tkeep, tlast) among NUM_SRC upstream requesters.
- Sits directly in front of the FIFO write side, in the FIFO's write clock domain.
- A grant is held from the first beat of a packet until its tlast beat is accepted, so packets never interleave in the FIFO.

Parameters:
- NUM_SRC, 4, number of requesters; legal range 2..8.
- DATA_W, 64, tdata width in bits; tkeep width is DATA_W/8.
- IDX_W, 2, width of the grant index; must equal ceil(log2(NUM_SRC)).

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  asynchronous, active-high reset.
- s_axis_tvalid  input  NUM_SRC  per-source valid, bit i = source i.
- s_axis_tready  output  NUM_SRC  per-source ready.
- s_axis_tdata  input  NUM_SRC*DATA_W  flattened; source i at [i*DATA_W +: DATA_W].
- s_axis_tkeep  input  NUM_SRC*DATA_W/8  flattened, same packing.
- s_axis_tlast  input  NUM_SRC  per-source last.
- m_axis_tvalid  output  1  to FIFO s_axis_tvalid.
- m_axis_tready  input  1  from FIFO s_axis_tready.
- m_axis_tdata  output  DATA_W  to FIFO.
- m_axis_tkeep  output  DATA_W/8  to FIFO.
- m_axis_tlast  output  1  to FIFO.
- grant  output  NUM_SRC  one-hot current owner; all-zero when idle.
- busy  output  1  high while a packet is in progress.

Behaviour:
- Reset values (asynchronous on areset):
  - state = IDLE; grant = 0; busy = 0; grant_idx = 0.
  - last_idx = NUM_SRC-1, so source 0 has first priority.
  - m_axis_tvalid = 0; s_axis_tready = 0.
- State machine:
  - IDLE:
    - m_axis_tvalid = 0, all s_axis_tready = 0.
    - If any s_axis_tvalid bit is set, select the first set bit searching upward from last_idx+1 (mod NUM_SRC).
    - Register that bit into grant_idx/grant, set busy, go to XFER.
    - If no bit is set, stay in IDLE.
  - XFER:
    - m_axis_tvalid/tdata/tkeep/tlast are driven combinationally from source grant_idx.
    - s_axis_tready[grant_idx] = m_axis_tready; all other readies = 0.
    - A beat transfers when m_axis_tvalid && m_axis_tready.
    - When the transferred beat has tlast = 1: last_idx <= grant_idx, grant <= 0, busy <= 0, go to IDLE.
- Latency and throughput:
  - First beat of a packet can transfer on the cycle after the grant decision.
  - Each packet costs one bubble cycle (IDLE) after its tlast.
  - Within a packet, full throughput: 1 beat per cycle when valid and ready are both high.
- Boundary conditions:
  - Granted source drops tvalid mid-packet: m_axis_tvalid goes 0, grant is held, no re-arbitration.
  - FIFO deasserts tready (full): the granted source is stalled, data is held by the source, grant is held.
  - Single-beat packet (tlast on the first beat): one XFER cycle, then IDLE.
  - Non-granted sources asserting tvalid see tready = 0 and must hold their data (AXIS rule). The arbiter never drops or duplicates a beat.
  - All sources requesting continuously: grant order is 0,1,2,3,0,… with one packet each.
  - Only one source requesting: it wins every arbitration.
  - Skipping: rotation skips non-requesting sources within the same IDLE cycle.
  - areset asserted mid-packet: immediately IDLE, all outputs low, last_idx = NUM_SRC-1. The partial packet already written to the FIFO is the upstream's problem; the arbiter does not generate tlast.
  - The arbiter never inspects tkeep; it passes through unchanged.

Optional Feature:
- Macro: AXIS_PKT_ARB_PKT_CNT_EN.
- When defined:
  - Adds output pkt_count [15:0]: total packets forwarded, incremented on each accepted tlast beat. Wraps 16'hFFFF -> 0. Reset to 0.
  - Adds output beat_count [15:0]: beats of the current packet, cleared on entry to XFER, incremented per accepted beat, saturating at 16'hFFFF.
- When undefined: neither port exists and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Reset, then source 0 sends 1 beat (tdata 64'hFFFFFFFFFFFFFFFF, tkeep 8'hCF, tlast 1) with m_axis_tready = 1 -> grant = 4'b0001 one cycle later; m_axis sees that exact beat with tkeep 8'hCF; grant returns to 0 the following cycle.
- Sources 0–3 each hold a 4-beat packet (data 64'h1111…, 64'h2222…, etc.), tready = 1 -> FIFO receives 16 beats in source order 0,1,2,3, no interleave, exactly one idle cycle between packets.
- Source 2 mid-packet; FIFO tready low for 3 cycles -> m_axis_tvalid stays 1 with stable data; s_axis_tready[2] = 0 for those 3 cycles; grant stays 4'b0100; no beat lost.
- Source 1 packet finishes while sources 1 and 3 both request -> next grant is 4'b1000, then 4'b0010.
- areset pulsed during beat 2 of a 4-beat packet -> all outputs low asynchronously; after release, source 0 wins when sources 0 and 2 request simultaneously.
- With AXIS_PKT_ARB_PKT_CNT_EN: 5 packets of 3 beats -> pkt_count = 5 and beat_count = 3 after the last tlast.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
// Round-robin, packet-granular arbiter sharing one AXI-Stream FIFO write
// port among NUM_SRC requesters. A grant is held from the first beat of a
// packet until its tlast beat is accepted, so packets never interleave.
//
// Optional build macro: AXIS_PKT_ARB_PKT_CNT_EN
//   adds pkt_count (packets forwarded, wrapping) and beat_count (beats of
//   the current packet, saturating). Without it neither port exists.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; round-robin pick among requesters, one bubble cycle
// XFER  | granted source streams to the FIFO until its tlast is accepted

module axis_pkt_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int IDX_W   = 2
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_SRC-1:0]          s_axis_tvalid,
    output logic [NUM_SRC-1:0]          s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]          s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic [DATA_W/8-1:0]         m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [NUM_SRC-1:0]          grant,
`ifdef AXIS_PKT_ARB_PKT_CNT_EN
    output logic [15:0]                 pkt_count,
    output logic [15:0]                 beat_count,
`endif
    output logic                        busy
);

    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               pick_vld;
    logic               beat_ok;
    logic               last_ok;
    logic               grant_take;

    logic [DATA_W-1:0]  src_data [NUM_SRC];
    logic [KEEP_W-1:0]  src_keep [NUM_SRC];

    // Unpack the flattened source buses into per-source lanes.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
            src_keep[i] = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        end
    end

    // Round-robin pick: walk downward from the farthest candidate so the
    // final assignment is the first requester after last_idx.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_idx = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand_idx = IDX_W'((int'(last_idx) + k) % NUM_SRC);
            if (s_axis_tvalid[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign grant_take = (state == ST_IDLE) && pick_vld;
    assign beat_ok    = m_axis_tvalid && m_axis_tready;
    assign last_ok    = beat_ok && m_axis_tlast;

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE on any request, leave XFER on accepted tlast.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_vld) state_nxt = ST_XFER;
            ST_XFER: if (last_ok)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: in XFER the granted source is wired straight through.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == ST_XFER) begin
            m_axis_tvalid            = s_axis_tvalid[grant_idx];
            m_axis_tdata             = src_data[grant_idx];
            m_axis_tkeep             = src_keep[grant_idx];
            m_axis_tlast             = s_axis_tlast[grant_idx];
            s_axis_tready[grant_idx] = m_axis_tready;
        end
    end

    // Ownership registers: capture the pick, release and remember on tlast.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            grant_idx <= '0;
            last_idx  <= IDX_W'(NUM_SRC - 1);
            grant     <= '0;
            busy      <= 1'b0;
        end else if (grant_take) begin
            grant_idx <= pick_idx;
            grant     <= NUM_SRC'(1) << pick_idx;
            busy      <= 1'b1;
        end else if ((state == ST_XFER) && last_ok) begin
            last_idx  <= grant_idx;
            grant     <= '0;
            busy      <= 1'b0;
        end
    end

`ifdef AXIS_PKT_ARB_PKT_CNT_EN
    // Packet counter wraps; beat counter restarts per packet and saturates.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_count  <= '0;
            beat_count <= '0;
        end else begin
            if (last_ok) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (grant_take) begin
                beat_count <= '0;
            end else if (beat_ok && (beat_count != 16'hFFFF)) begin
                beat_count <= beat_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: per-source beat queues feed the DUT, the
// expected FIFO-side beat stream sits in a scoreboard queue, and a monitor
// compares every accepted m_axis beat (data, keep, last, owner, spacing).

module tb_axis_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int          src;
        int          gap;
    } beat_t;

    logic              aclk;
    logic              areset;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N-1:0]      s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic [N-1:0]      grant;
    logic              busy;
`ifdef AXIS_PKT_ARB_PKT_CNT_EN
    logic [15:0]       pkt_count;
    logic [15:0]       beat_count;
`endif

    beat_t srcq [N][$];
    beat_t expq [$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    last_cyc = 0;

    axis_pkt_arbiter #(.NUM_SRC(N), .DATA_W(DW), .IDX_W(2)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .grant         (grant),
`ifdef AXIS_PKT_ARB_PKT_CNT_EN
        .pkt_count     (pkt_count),
        .beat_count    (beat_count),
`endif
        .busy          (busy)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add_pkt(input int src, input int nb, input logic [63:0] base,
                           input logic [7:0] keep, input int gap0, input int gapn);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.d   = base + 64'(i);
            b.k   = keep ^ 8'(i);
            b.l   = (i == nb - 1);
            b.src = src;
            b.gap = (i == 0) ? gap0 : gapn;
            srcq[src].push_back(b);
            expq.push_back(b);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[i*DW +: DW] = srcq[i][0].d;
                s_axis_tkeep[i*KW +: KW] = srcq[i][0].k;
                s_axis_tlast[i]          = srcq[i][0].l;
            end else begin
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tkeep[i*KW +: KW] = '0;
                s_axis_tlast[i]          = 1'b0;
            end
        end
    endtask

    // Source driver: handshake sampled mid-cycle, queue advanced after the edge.
    initial begin
        logic [N-1:0] hs;
        drive_sources();
        forever begin
            @(negedge aclk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            drive_sources();
        end
    end

    // Monitor: every accepted FIFO-side beat must match the scoreboard head.
    initial begin
        beat_t        e;
        int           gap_now;
        logic [N-1:0] g_exp;
        forever begin
            @(negedge aclk);
            if (!areset && m_axis_tvalid && m_axis_tready) begin
                gap_now  = cyc - last_cyc;
                last_cyc = cyc;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got data=%h grant=%b want no beat", m_axis_tdata, grant);
                end else begin
                    e     = expq.pop_front();
                    g_exp = N'(1) << e.src;
                    if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k || m_axis_tlast !== e.l ||
                        grant !== g_exp || s_axis_tready[e.src] !== 1'b1) begin
                        bad++;
                        $display("FAIL beat: got data=%h keep=%h last=%b grant=%b want data=%h keep=%h last=%b grant=%b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, grant, e.d, e.k, e.l, g_exp);
                    end
                    if (e.gap != 0) begin
                        total++;
                        if (gap_now != e.gap) begin
                            bad++;
                            $display("FAIL beat_spacing: got %0d cycles want %0d (data=%h)", gap_now, e.gap, e.d);
                        end
                    end
                end
            end
        end
    end

    function automatic bit srcs_pending();
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string nm);
        int n = 0;
        while ((expq.size() != 0 || busy || srcs_pending()) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s_drain: got %0d beats outstanding want 0", nm, expq.size());
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        bit found;
        areset        = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_grant",  grant, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_sready", s_axis_tready, 0);
        areset = 1'b0;
        @(negedge aclk);

        // single-beat packet from source 0
        add_pkt(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hCF, 0, 1);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (grant != 0) begin found = 1; break; end
        end
        chk("t1_grant_seen", found, 1);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1);
        chk("t1_keep", m_axis_tkeep, 8'hCF);
        @(negedge aclk);
        chk("t1_grant_release", grant, 0);
        chk("t1_busy_release", busy, 0);
        drain("t1");

        // all four sources, 4 beats each, rotation 0,1,2,3
        do_reset();
        add_pkt(0, 4, 64'h1111_1111_1111_1110, 8'hFF, 0, 1);
        add_pkt(1, 4, 64'h2222_2222_2222_2220, 8'h0F, 2, 1);
        add_pkt(2, 4, 64'h3333_3333_3333_3330, 8'hF0, 2, 1);
        add_pkt(3, 4, 64'h4444_4444_4444_4440, 8'h3C, 2, 1);
        drain("t2");

        // FIFO backpressure during source 2's third beat
        add_pkt(2, 4, 64'h5555_5555_5555_5550, 8'h0F, 0, 0);
        for (int i = 0; i < 50; i++) begin
            @(posedge aclk);
            #3;
            if (expq.size() <= 2) break;
        end
        m_axis_tready = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            chk("t3_mvalid_held", m_axis_tvalid, 1);
            chk("t3_data_held", m_axis_tdata, 64'h5555_5555_5555_5552);
            chk("t3_sready2_low", s_axis_tready[2], 0);
            chk("t3_grant_held", grant, 4'b0100);
        end
        @(posedge aclk);
        #3;
        m_axis_tready = 1'b1;
        drain("t3");

        // source 1 finishes while 1 and 3 request: 3 next, then 1
        add_pkt(1, 2, 64'h6666_6666_6666_6660, 8'h81, 0, 1);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (grant == 4'b0010) begin found = 1; break; end
        end
        chk("t4_grant1_seen", found, 1);
        add_pkt(3, 2, 64'h7777_7777_7777_7770, 8'hC3, 2, 1);
        add_pkt(1, 2, 64'h9999_9999_9999_9990, 8'h5A, 2, 1);
        drain("t4");

        // reset during beat 2 of a 4-beat packet
        add_pkt(0, 4, 64'hAAAA_AAAA_AAAA_AAA0, 8'hFF, 0, 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge aclk);
            #3;
            if (expq.size() <= 3) break;
        end
        chk("t5_mvalid_before", m_axis_tvalid, 1);
        areset = 1'b1;
        #1;
        chk("t5_mvalid_async", m_axis_tvalid, 0);
        chk("t5_mlast_async", m_axis_tlast, 0);
        chk("t5_grant_async", grant, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_sready_async", s_axis_tready, 0);
        srcq[0].delete();
        expq.delete();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        add_pkt(0, 2, 64'hBBBB_BBBB_BBBB_BBB0, 8'h11, 0, 1);
        add_pkt(2, 2, 64'hCCCC_CCCC_CCCC_CCC0, 8'h22, 2, 1);
        drain("t5");

`ifdef AXIS_PKT_ARB_PKT_CNT_EN
        do_reset();
        for (int p = 0; p < 5; p++) begin
            add_pkt(1, 3, 64'hD000_0000_0000_0000 + 64'(p * 16), 8'hE7, 0, 1);
        end
        drain("t6");
        chk("t6_pkt_count", pkt_count, 5);
        chk("t6_beat_count", beat_count, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
